// File: rtl/dsp_isa_pkg.sv
// Shared definitions for the custom-0 DSP issue sequencer: opcode, field
// slices, FSM state encoding and error codes.
package dsp_isa_pkg;

    localparam int SEQ_DEPTH   = 32;
    localparam int SEQ_AW      = 5;
    localparam int SEQ_TIMEOUT = 4096;

    // Only custom-0 instructions are forwarded to the commit stage
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    // Error codes reported on err_code
    localparam logic [1:0] ERRC_NONE    = 2'b00;
    localparam logic [1:0] ERRC_ILLEGAL = 2'b01;
    localparam logic [1:0] ERRC_TIMEOUT = 2'b10;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } seq_state_t;

    // Instruction field slices
    function automatic logic [6:0] funct7_of(input logic [31:0] w);
        return w[31:25];
    endfunction

    function automatic logic [17:0] payload_of(input logic [31:0] w);
        return w[24:7];
    endfunction

    function automatic logic [6:0] opcode_of(input logic [31:0] w);
        return w[6:0];
    endfunction

endpackage

// File: rtl/dsp_prog_ram.sv
// Program store: DEPTH x 32 words, one write port and one registered read
// port (data appears the cycle after the address is presented).
module dsp_prog_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Synchronous write and registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dsp_issue_seq.sv
// Issue sequencer: runs a host-loaded program of custom-0 instructions,
// issuing one request at a time to the commit stage and waiting for its
// response before fetching the next. Illegal opcodes and response timeouts
// park the sequencer in ERR with a sticky error code.
module dsp_issue_seq
    import dsp_isa_pkg::*;
#(
    parameter int         DEPTH   = SEQ_DEPTH,
    parameter int         AW      = SEQ_AW,
    parameter int         TIMEOUT = SEQ_TIMEOUT,
    parameter logic [6:0] OPCODE  = OPC_CUSTOM0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          req_vaild,
    input  logic          req_ready,
    output logic [31:0]   r_out,
    input  logic          rsp_vaild,
    output logic          rsp_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW-1:0] pc
);

    localparam int TW = $clog2(TIMEOUT);

    seq_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   r_out_q, r_out_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic [31:0]   ram_rdata;
    logic [AW:0]   len_sat;
    logic          is_last;
    logic          timeout_hit;
    logic          illegal_op;

    // Lengths beyond the program store are clamped to its size
    assign len_sat     = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign is_last     = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
    assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));
    assign illegal_op  = (opcode_of(ram_rdata) != OPCODE);

    // Writes are blocked while a program runs so the RAM is stable mid-run
    dsp_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (prog_we && !busy),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (ram_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d = (prog_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = illegal_op ? ST_ERR : ST_ISSUE;
            ST_ISSUE: begin
                if (req_ready) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // A response in the final timer cycle still wins over the timeout
                if (rsp_vaild) begin
                    state_d = is_last ? ST_DONE : ST_FETCH;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        req_vaild = (state_q == ST_ISSUE);
        rsp_ready = (state_q == ST_WAIT_RSP);
        done      = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE) && (state_q != ST_ERR);
    end

    // Datapath next-state: pc, run length, response timer, issued word, error
    always_comb begin
        pc_d       = pc_q;
        len_d      = len_q;
        timer_d    = timer_q;
        r_out_d    = r_out_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    len_d      = len_sat;
                    pc_d       = '0;
                    timer_d    = '0;
                    err_d      = 1'b0;
                    err_code_d = ERRC_NONE;
                end
            end
            ST_LOAD: begin
                r_out_d = ram_rdata;
                if (illegal_op) begin
                    err_d      = 1'b1;
                    err_code_d = ERRC_ILLEGAL;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
            end
            ST_WAIT_RSP: begin
                if (rsp_vaild) begin
                    if (!is_last) begin
                        pc_d = pc_q + AW'(1);
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = ERRC_TIMEOUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            len_q      <= '0;
            timer_q    <= '0;
            r_out_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERRC_NONE;
        end else begin
            pc_q       <= pc_d;
            len_q      <= len_d;
            timer_q    <= timer_d;
            r_out_q    <= r_out_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign r_out    = r_out_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_dsp_issue_seq.sv
// Scoreboard bench for dsp_issue_seq: a run-level model predicts the event
// sequence (requests, done, errors); a negedge monitor pops and compares.
module tb_dsp_issue_seq;

    localparam int         DEPTH   = 32;
    localparam int         AW      = 5;
    localparam int         TIMEOUT = 4096;
    localparam logic [6:0] OPC     = 7'b0001011;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          req_ready = 1'b0;
    logic          rsp_vaild = 1'b0;
    logic          req_vaild;
    logic [31:0]   r_out;
    logic          rsp_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW-1:0] pc;

    always #5 clk = ~clk;

    dsp_issue_seq dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .req_vaild (req_vaild),
        .req_ready (req_ready),
        .r_out     (r_out),
        .rsp_vaild (rsp_vaild),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .pc        (pc)
    );

    typedef enum int {EV_REQ, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] val;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] mem [DEPTH];
    int          tests  = 0;
    int          fails  = 0;
    int          events = 0;
    int          req_dly = 0;
    int          rsp_dly = 0;
    bit          noise = 1'b0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void pop_check(string nm, ev_kind_t k, logic [31:0] v);
        ev_t e;
        tests++;
        events++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected event kind=%0d val=%08h, none expected", nm, k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v) begin
                fails++;
                $display("FAIL %s: got kind=%0d val=%08h, expected kind=%0d val=%08h",
                         nm, k, v, e.kind, e.val);
            end
        end
    endfunction

    function automatic void push_ev(ev_kind_t k, logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    // Commit-stage peer: ready/response after programmable waits
    initial begin
        int rq;
        int rs;
        rq = 0;
        rs = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                rq = 0;
                rs = 0;
                req_ready = 1'b0;
                rsp_vaild = 1'b0;
            end else begin
                rq = req_vaild ? rq + 1 : 0;
                rs = rsp_ready ? rs + 1 : 0;
                req_ready = req_vaild ? (rq > req_dly) : (noise && $urandom_range(0, 1) == 1);
                rsp_vaild = rsp_ready ? (rs > rsp_dly) : (noise && $urandom_range(0, 1) == 1);
            end
        end
    end

    // Monitor state
    bit          prev_pend, prev_req_v, prev_done, prev_err, gap_on;
    logic [31:0] prev_r_out;
    int          req_run, gap, wait_run, last_wait;

    always @(negedge clk) begin
        if (reset) begin
            prev_pend  = 1'b0;
            prev_req_v = 1'b0;
            prev_done  = 1'b0;
            prev_err   = 1'b0;
            gap_on     = 1'b0;
            gap        = 0;
            req_run    = 0;
            wait_run   = 0;
            last_wait  = 0;
        end else begin
            if (gap_on) gap++;
            if (req_vaild) req_run++; else req_run = 0;
            if (rsp_ready) begin
                wait_run++;
            end else if (wait_run != 0) begin
                last_wait = wait_run;
                wait_run  = 0;
            end
            if (prev_pend) check("req_hold", {req_vaild, r_out}, {1'b1, prev_r_out});
            if (req_vaild && !prev_req_v && gap_on) begin
                check("issue_latency", gap, 3);
                gap_on = 1'b0;
            end
            if (req_vaild && req_ready) begin
                $display("[TB] req pc=%0d word=%08h", pc, r_out);
                check("ready_wait", req_run, req_dly + 1);
                pop_check("req", EV_REQ, r_out);
            end
            if (rsp_vaild && rsp_ready) begin
                gap    = 0;
                gap_on = 1'b1;
            end
            if (start && !busy) begin
                gap    = 0;
                gap_on = 1'b1;
            end
            if (prev_done) check("done_width", done, 0);
            if (done) begin
                $display("[TB] done pc=%0d", pc);
                pop_check("done", EV_DONE, {27'd0, pc});
                gap_on = 1'b0;
            end
            if (err && !prev_err) begin
                $display("[TB] err code=%0d", err_code);
                pop_check("err", EV_ERR, {30'd0, err_code});
                check("err_quiet", {busy, req_vaild, rsp_ready}, 0);
                if (err_code == 2'b10) check("timeout_len", last_wait, TIMEOUT);
                gap_on = 1'b0;
            end
            prev_pend  = req_vaild && !req_ready;
            prev_r_out = r_out;
            prev_req_v = req_vaild;
            prev_done  = done;
            prev_err   = err;
        end
    end

    task automatic write_word(input int addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        prog_we   = 1'b1;
        prog_addr = addr[AW-1:0];
        prog_data = data;
        mem[addr] = data;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    // Predict the run from program contents and peer timing, then execute it
    task automatic run_prog(input int len, input int rdly, input int sdly,
                            input bit poke, input bit co_wr, input logic [31:0] co_word);
        int n;
        int pushed;
        int target;
        int cyc;
        bit stop;
        req_dly = rdly;
        rsp_dly = sdly;
        if (co_wr) mem[0] = co_word;
        n = (len > DEPTH) ? DEPTH : len;
        pushed = 0;
        stop = 1'b0;
        for (int i = 0; i < n && !stop; i++) begin
            if (mem[i][6:0] != OPC) begin
                push_ev(EV_ERR, 32'd1);
                pushed++;
                stop = 1'b1;
            end else begin
                push_ev(EV_REQ, mem[i]);
                pushed++;
                if (sdly >= TIMEOUT) begin
                    push_ev(EV_ERR, 32'd2);
                    pushed++;
                    stop = 1'b1;
                end
            end
        end
        if (!stop) begin
            push_ev(EV_DONE, (n == 0) ? 32'd0 : 32'(n - 1));
            pushed++;
        end
        target = events + pushed;
        $display("[TB] run len=%0d req_dly=%0d rsp_dly=%0d events=%0d", len, rdly, sdly, pushed);
        @(posedge clk);
        #1;
        prog_len = len[AW:0];
        start    = 1'b1;
        if (co_wr) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = co_word;
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        @(negedge clk);
        check("err_cleared", err, 0);
        if (len == 0) check("empty_done", done, 1);
        if (poke) begin
            @(posedge clk);
            #1;
            start     = 1'b1;
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = 32'hDEADBEEF;
            @(posedge clk);
            #1;
            start   = 1'b0;
            prog_we = 1'b0;
        end
        cyc = 0;
        while (events < target && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (events < target) begin
            tests++;
            fails++;
            $display("FAIL run_end: saw %0d events, required %0d within budget", events, target);
        end
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] w;
        int cyc;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", {req_vaild, rsp_ready, busy, done, err, err_code, pc, r_out}, 0);

        // Three-instruction program, responses after 2 cycles
        write_word(0, 32'h0054A90B);
        write_word(1, 32'h407FFF8B);
        write_word(2, 32'h4200000B);
        run_prog(3, 0, 2, 1'b0, 1'b0, 32'd0);
        check("pc_after_done", pc, 2);
        check("err_after_done", err, 0);

        // Commit back-pressure for 10 cycles
        run_prog(3, 10, 0, 1'b0, 1'b0, 32'd0);

        // Illegal opcode in slot 1
        write_word(1, 32'h00000013);
        run_prog(3, 0, 0, 1'b0, 1'b0, 32'd0);
        check("err_code_illegal", {err, err_code}, 3'b101);
        check("busy_in_err", busy, 0);
        write_word(1, 32'h407FFF8B);
        run_prog(3, 1, 1, 1'b0, 1'b0, 32'd0);
        check("err_code_clear", {err, err_code}, 0);

        // Response in the last timer cycle, then a real timeout
        run_prog(1, 0, TIMEOUT - 1, 1'b0, 1'b0, 32'd0);
        check("late_rsp_ok", err, 0);
        run_prog(1, 0, TIMEOUT, 1'b0, 1'b0, 32'd0);
        check("err_code_timeout", {err, err_code}, 3'b110);

        // Empty program, ignored start/write while busy, write with start
        run_prog(0, 0, 0, 1'b0, 1'b0, 32'd0);
        run_prog(3, 2, 2, 1'b1, 1'b0, 32'd0);
        run_prog(3, 0, 0, 1'b0, 1'b0, 32'd0);
        run_prog(2, 0, 0, 1'b0, 1'b1, 32'h0000120B);

        // Oversized length saturates to the full store
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            w[6:0] = OPC;
            write_word(i, w);
        end
        run_prog(33, 0, 0, 1'b0, 1'b0, 32'd0);
        check("pc_saturated", pc, DEPTH - 1);

        // Reset while waiting for a response
        req_dly = 0;
        rsp_dly = 50;
        push_ev(EV_REQ, mem[0]);
        @(posedge clk);
        #1;
        prog_len = 6'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!rsp_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_wait", rsp_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_midrun", {req_vaild, rsp_ready, busy, done, err, err_code, pc, r_out}, 0);
        check("reset_req_seen", exp_q.size(), 0);
        exp_q.delete();
        run_prog(3, 0, 0, 1'b0, 1'b0, 32'd0);

        // Randomized programs, lengths and peer timing with channel noise
        noise = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = $urandom;
                if ($urandom_range(0, 9) != 0) w[6:0] = OPC;
                write_word(i, w);
            end
            run_prog($urandom_range(0, 34), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'b0, 1'b0, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
